seg_scan_ctrl: RTL

Event-counting display controller for the board's 4-digit multiplexed 7-segment display. It counts rising edges of a 1-bit event line, such as the `z` output of the sequence detectors, in 4-digit BCD. It then time-shares the single active-low segment bus `disp` among four digits, with a blanking gap between digits. It sits between a detector block and the board pins and replaces static single-digit drive.

---
 rtl/seg_scan_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Event counter with 4-digit BCD count, multiplexed onto an active-low 7-segment display.
// Optional LZ_BLANK_EN macro enables leading-zero blanking of digits 3..1.
module seg_scan_ctrl #(
    parameter int DIV_W     = 16,
    parameter int BLANK_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        evt,
    input  logic        clr,
    output logic [7:0]  disp,
    output logic [3:0]  an,
    output logic [15:0] count,
    output logic        ovf
);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t             state_reg;
    logic               evt_q_reg;
    logic [DIV_W-1:0]   presc_reg;
    logic [7:0]         blank_cnt_reg;
    logic [1:0]         idx_reg;
    logic [15:0]        shown_reg;

    logic               inc;
    logic [4:0]         carry;
    logic [15:0]        count_next;
    logic [1:0]         idx_next;
    logic [15:0]        frame_src;
    logic [3:0]         nib;
    logic [3:0]         hi_zero;
    logic [7:0]         seg_next;
    logic [3:0]         an_next;

    function automatic logic [7:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hBF;
        endcase
    endfunction

    assign inc      = evt & ~evt_q_reg;
    assign carry[0] = inc;

    // Ripple-carry BCD digits; carry[4] marks the 9999 -> 0000 wrap.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            logic [3:0] dig;
            assign dig = count[4*gi +: 4];
            assign carry[gi+1] = carry[gi] & (dig == 4'd9);
            assign count_next[4*gi +: 4] = !carry[gi] ? dig :
                                           (dig == 4'd9) ? 4'd0 : dig + 4'd1;
        end
    endgenerate

    assign idx_next  = idx_reg + 2'd1;
    // On wrap to digit 0 the frame takes a fresh snapshot, so decode from count directly.
    assign frame_src = (idx_next == 2'd0) ? count : shown_reg;
    assign nib       = frame_src[{idx_next, 2'b00} +: 4];
    assign an_next   = ~(4'b0001 << idx_next);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_hizero
            assign hi_zero[gi] = (frame_src[15:4*gi] == '0);
        end
    endgenerate

    always_comb begin
        seg_next = seg7(nib);
`ifdef LZ_BLANK_EN
        if (idx_next != 2'd0 && hi_zero[idx_next])
            seg_next = 8'hFF;
`endif
        if (idx_next == 2'd3 && ovf)
            seg_next = seg_next & 8'h7F;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_q_reg <= 1'b0;
            count     <= '0;
            ovf       <= 1'b0;
        end else begin
            evt_q_reg <= evt;
            if (clr) begin
                count <= '0;
                ovf   <= 1'b0;
            end else begin
                count <= count_next;
                if (carry[4])
                    ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= BLANK;
            presc_reg     <= '0;
            blank_cnt_reg <= '0;
            idx_reg       <= 2'd3;
            shown_reg     <= '0;
            an            <= 4'hF;
            disp          <= 8'hFF;
        end else begin
            presc_reg <= presc_reg + DIV_W'(1);
            case (state_reg)
                BLANK: begin
                    if (blank_cnt_reg == 8'(BLANK_CYC - 1)) begin
                        blank_cnt_reg <= '0;
                        state_reg     <= SHOW;
                        idx_reg       <= idx_next;
                        if (idx_next == 2'd0)
                            shown_reg <= count;
                        an            <= an_next;
                        disp          <= seg_next;
                    end else begin
                        blank_cnt_reg <= blank_cnt_reg + 8'd1;
                    end
                end
                SHOW: begin
                    if (&presc_reg) begin
                        state_reg <= BLANK;
                        an        <= 4'hF;
                        disp      <= 8'hFF;
                    end
                end
                default: state_reg <= BLANK;
            endcase
        end
    end

endmodule
